// File: rtl/sc_level_control.sv
// Level/game sequencer for the racing game: start, per-level progress goal,
// end-of-level hold pulse, game over on crash and win after the last level.
module sc_level_control #(
  parameter logic [4:0]  PROGRESS_GOAL = 5'd24,
  parameter int unsigned NUM_LEVELS    = 4,
  parameter int unsigned END_HOLD      = 8
) (
  input  logic       SC_LEVEL_CONTROL_CLOCK_50,
  input  logic       SC_LEVEL_CONTROL_RESET_InLow,
  input  logic [4:0] SC_LEVEL_CONTROL_Progress_InBus,
  input  logic       SC_LEVEL_CONTROL_Start_InLow,
  input  logic       SC_LEVEL_CONTROL_Crash_InLow,
  output logic       SC_LEVEL_CONTROL_EndLevel_Out,
  output logic       SC_LEVEL_CONTROL_EndGame_Out,
  output logic [1:0] SC_LEVEL_CONTROL_Level_OutBus,
  output logic [2:0] SC_LEVEL_CONTROL_State_OutBus,
  output logic       SC_LEVEL_CONTROL_Win_Out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAYING   = 3'd1,
    S_LEVEL_END = 3'd2,
    S_GAME_OVER = 3'd3,
    S_GAME_WON  = 3'd4
  } state_t;

  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(END_HOLD - 1);

  // Raw 3-bit register so the unused encodings 5..7 stay representable
  // and can be recovered from.
  logic [2:0] r_state;
  state_t     w_next;
  logic [1:0] r_level;
  logic [7:0] r_hold;
  logic       r_start_prev;
  logic       r_start_armed;
  logic       w_start;
  logic       w_goal;
  logic       w_crash;
  logic       w_hold_done;

  // The armed flag keeps a button held low through reset from looking like
  // a fresh press once reset releases.
  assign w_start     = r_start_armed & r_start_prev & ~SC_LEVEL_CONTROL_Start_InLow;
  assign w_goal      = (SC_LEVEL_CONTROL_Progress_InBus >= PROGRESS_GOAL);
  assign w_crash     = ~SC_LEVEL_CONTROL_Crash_InLow;
  assign w_hold_done = (r_hold == '0);

  always_ff @(posedge SC_LEVEL_CONTROL_CLOCK_50 or negedge SC_LEVEL_CONTROL_RESET_InLow) begin
    if (!SC_LEVEL_CONTROL_RESET_InLow) begin
      r_start_prev  <= 1'b1;
      r_start_armed <= 1'b0;
    end else begin
      r_start_prev  <= SC_LEVEL_CONTROL_Start_InLow;
      r_start_armed <= r_start_armed | SC_LEVEL_CONTROL_Start_InLow;
    end
  end

  always_ff @(posedge SC_LEVEL_CONTROL_CLOCK_50 or negedge SC_LEVEL_CONTROL_RESET_InLow) begin
    if (!SC_LEVEL_CONTROL_RESET_InLow) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        w_next = w_start ? S_PLAYING : S_IDLE;
      end
      S_PLAYING: begin
        if (w_crash) begin
          w_next = S_GAME_OVER;
        end else if (w_goal) begin
          w_next = S_LEVEL_END;
        end else begin
          w_next = S_PLAYING;
        end
      end
      S_LEVEL_END: begin
        if (!w_hold_done) begin
          w_next = S_LEVEL_END;
        end else if (r_level == LAST_LEVEL) begin
          w_next = S_GAME_WON;
        end else begin
          w_next = S_PLAYING;
        end
      end
      S_GAME_OVER: begin
        w_next = w_start ? S_PLAYING : S_GAME_OVER;
      end
      S_GAME_WON: begin
        w_next = w_start ? S_PLAYING : S_GAME_WON;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SC_LEVEL_CONTROL_CLOCK_50 or negedge SC_LEVEL_CONTROL_RESET_InLow) begin
    if (!SC_LEVEL_CONTROL_RESET_InLow) begin
      r_level <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_GAME_OVER, S_GAME_WON: begin
          if (w_start) begin
            r_level <= '0;
          end
        end
        S_LEVEL_END: begin
          if (w_hold_done && (r_level != LAST_LEVEL)) begin
            r_level <= r_level + 2'd1;
          end
        end
        S_PLAYING: begin
          r_level <= r_level;
        end
        default: begin
          r_level <= '0;
        end
      endcase
    end
  end

  // Loaded on entry to LEVEL_END so EndLevel stays low for END_HOLD cycles.
  always_ff @(posedge SC_LEVEL_CONTROL_CLOCK_50 or negedge SC_LEVEL_CONTROL_RESET_InLow) begin
    if (!SC_LEVEL_CONTROL_RESET_InLow) begin
      r_hold <= '0;
    end else if (r_state != S_LEVEL_END) begin
      r_hold <= (w_next == S_LEVEL_END) ? HOLD_LOAD : '0;
    end else if (!w_hold_done) begin
      r_hold <= r_hold - 8'd1;
    end
  end

  always_comb begin
    SC_LEVEL_CONTROL_EndGame_Out  = 1'b0;
    SC_LEVEL_CONTROL_EndLevel_Out = 1'b1;
    SC_LEVEL_CONTROL_Win_Out      = 1'b0;
    case (r_state)
      S_PLAYING: begin
        SC_LEVEL_CONTROL_EndGame_Out = 1'b1;
      end
      S_LEVEL_END: begin
        SC_LEVEL_CONTROL_EndGame_Out  = 1'b1;
        SC_LEVEL_CONTROL_EndLevel_Out = 1'b0;
      end
      S_GAME_WON: begin
        SC_LEVEL_CONTROL_Win_Out = 1'b1;
      end
      default: begin
        SC_LEVEL_CONTROL_EndGame_Out = 1'b0;
      end
    endcase
  end

  assign SC_LEVEL_CONTROL_State_OutBus = r_state;
  assign SC_LEVEL_CONTROL_Level_OutBus = r_level;

endmodule

// File: tb/tb_sc_level_control.sv
// Self-checking bench for sc_level_control: directed scenarios followed by
// randomized play, all compared against a cycle-level game model.
module tb_sc_level_control;

  localparam int GOAL   = 24;
  localparam int LEVELS = 4;
  localparam int HOLD   = 8;

  logic       clk;
  logic       rst_n;
  logic [4:0] progress;
  logic       start_n;
  logic       crash_n;
  logic       end_level;
  logic       end_game;
  logic [1:0] level;
  logic [2:0] state;
  logic       win;

  int n_cmp;
  int n_err;

  // Reference model: game phase, level, cycles of end-of-level pulse left.
  int m_phase;
  int m_level;
  int m_left;
  int m_prev;
  int m_armed;

  sc_level_control dut (
    .SC_LEVEL_CONTROL_CLOCK_50      (clk),
    .SC_LEVEL_CONTROL_RESET_InLow   (rst_n),
    .SC_LEVEL_CONTROL_Progress_InBus(progress),
    .SC_LEVEL_CONTROL_Start_InLow   (start_n),
    .SC_LEVEL_CONTROL_Crash_InLow   (crash_n),
    .SC_LEVEL_CONTROL_EndLevel_Out  (end_level),
    .SC_LEVEL_CONTROL_EndGame_Out   (end_game),
    .SC_LEVEL_CONTROL_Level_OutBus  (level),
    .SC_LEVEL_CONTROL_State_OutBus  (state),
    .SC_LEVEL_CONTROL_Win_Out       (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_level = 0;
    m_left  = 0;
    m_prev  = 1;
    m_armed = 0;
  endtask

  task automatic model_step();
    bit press;
    press = (m_armed != 0) && (m_prev != 0) && (start_n == 1'b0);
    case (m_phase)
      0: if (press) begin m_phase = 1; m_level = 0; end
      1: begin
        if (!crash_n) m_phase = 3;
        else if (int'(progress) >= GOAL) begin m_phase = 2; m_left = HOLD; end
      end
      2: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_level == LEVELS - 1) m_phase = 4;
          else begin m_level = m_level + 1; m_phase = 1; end
        end
      end
      3, 4: if (press) begin m_phase = 1; m_level = 0; end
      default: begin m_phase = 0; m_level = 0; end
    endcase
    m_prev = int'(start_n);
    if (start_n) m_armed = 1;
  endtask

  task automatic check_all();
    chk("state", int'(state), m_phase);
    chk("level", int'(level), m_level);
    chk("endgame", int'(end_game), (m_phase == 1 || m_phase == 2) ? 1 : 0);
    chk("endlevel", int'(end_level), (m_phase == 2) ? 0 : 1);
    chk("win", int'(win), (m_phase == 4) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input int p, input bit c, input bit s, input int n);
    progress = 5'(p);
    crash_n  = c;
    start_n  = s;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset pulse in mid-cycle; the start level is applied with it.
  task automatic pulse_reset(input bit s);
    #2;
    start_n = s;
    rst_n   = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int lows;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start_n  = 1'b1;
    crash_n  = 1'b1;
    progress = '0;
    model_reset();
    #12;
    check_all();
    chk("reset_endlevel", int'(end_level), 1);
    rst_n = 1'b1;
    #4;

    // Start edge from IDLE
    drive(0, 1, 1, 2);
    drive(0, 1, 0, 1);
    chk("start_state", int'(state), 1);
    chk("start_endgame", int'(end_game), 1);

    // Progress ramp into LEVEL_END; measure the EndLevel low pulse
    for (int p = 0; p <= GOAL; p++) drive(p, 1, 0, 1);
    chk("goal_state", int'(state), 2);
    lows = 1;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 1);
      if (!end_level) lows++;
    end
    chk("hold_len", lows, HOLD);
    chk("lvl1", int'(level), 1);

    // Finish remaining levels to reach GAME_WON
    for (int l = 1; l < LEVELS; l++) begin
      drive(GOAL, 1, 0, 1);
      drive(0, 1, 0, HOLD + 2);
    end
    chk("won_state", int'(state), 4);
    chk("won_level", int'(level), LEVELS - 1);
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 1);
    chk("restart_win", int'(win), 0);

    // Crash and goal together: crash wins
    drive(GOAL, 0, 0, 1);
    chk("crash_state", int'(state), 3);
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 1);

    // Crash during LEVEL_END is ignored
    drive(31, 1, 0, 1);
    drive(0, 0, 0, 3);
    drive(0, 1, 0, HOLD);
    chk("crash_ignored_lvl", int'(level), 1);

    // Start edge while playing has no effect
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 2);
    chk("start_in_play", int'(state), 1);

    // Unused encoding recovers to IDLE
    @(negedge clk);
    force dut.r_state = 3'd6;
    #1;
    release dut.r_state;
    m_phase = 6;
    cycle();
    chk("illegal_recover", int'(state), 0);

    // Reset in the middle of LEVEL_END with start held low through release
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 1);
    drive(GOAL, 1, 0, 1);
    drive(0, 1, 0, 4);
    pulse_reset(1'b0);
    drive(0, 1, 0, 4);
    chk("held_start_idle", int'(state), 0);
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 1);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) pulse_reset(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) start_n = ~start_n;
      crash_n  = ($urandom_range(0, 79) != 0);
      progress = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 23));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sc_level_control.md
SC_LEVEL_CONTROL -- requirements
Module: sc_level_control

Interface
REQ-001 Parameter PROGRESS_GOAL, default 5'd24: progress value at which a level is complete; legal range 1..31.
REQ-002 Parameter NUM_LEVELS, default 4: levels per game; legal range 1..4.
REQ-003 Parameter END_HOLD, default 8: cycles EndLevel is held low; legal range 2..255.
REQ-004 SC_LEVEL_CONTROL_CLOCK_50  in  1  single system clock; all state updates on its rising edge.
REQ-005 SC_LEVEL_CONTROL_RESET_InLow  in  1  asynchronous, active-low reset.
REQ-006 SC_LEVEL_CONTROL_Progress_InBus  in  5  unsigned level-progress count from the progress counter.
REQ-007 SC_LEVEL_CONTROL_Start_InLow  in  1  start button, active low, already synchronized.
REQ-008 SC_LEVEL_CONTROL_Crash_InLow  in  1  fatal crash / fuel-out, active low, level-sensitive.
REQ-009 SC_LEVEL_CONTROL_EndLevel_Out  out  1  active low; 0 commands the progress counter to clear.
REQ-010 SC_LEVEL_CONTROL_EndGame_Out  out  1  1 = game running; 0 forces the progress counter to zero.
REQ-011 SC_LEVEL_CONTROL_Level_OutBus  out  2  current level index, 0-based.
REQ-012 SC_LEVEL_CONTROL_State_OutBus  out  3  FSM state: IDLE=0, PLAYING=1, LEVEL_END=2, GAME_OVER=3, GAME_WON=4.
REQ-013 SC_LEVEL_CONTROL_Win_Out  out  1  1 = all levels completed.

Function
REQ-014 The FSM SHALL be Moore; all outputs SHALL be decoded from registers only, with no combinational input-to-output path.
REQ-015 A start event SHALL be a registered falling edge of Start_InLow: previous sample 1, current sample 0. The edge register SHALL reset to 1.
REQ-016 IDLE: outputs EndGame=0, EndLevel=1. A start event SHALL move the FSM to PLAYING on the next clock with Level=0.
REQ-017 PLAYING: outputs EndGame=1, EndLevel=1.
- Crash_InLow=0 SHALL move the FSM to GAME_OVER.
- Otherwise, Progress_InBus >= PROGRESS_GOAL (unsigned 5-bit compare) SHALL move the FSM to LEVEL_END.
- If both occur in the same cycle, the crash SHALL win.
REQ-018 LEVEL_END: outputs EndGame=1, EndLevel=0.
- An 8-bit hold counter SHALL load END_HOLD-1 on entry and decrement each cycle.
- EndLevel SHALL be low for exactly END_HOLD cycles.
REQ-019 When the hold counter reaches 0, the FSM SHALL take one of two exits:
- If Level == NUM_LEVELS-1: go to GAME_WON, with Level unchanged.
- Otherwise: increment Level by 1 and return to PLAYING.
REQ-020 In LEVEL_END, crash and start SHALL be ignored.
REQ-021 GAME_OVER: outputs EndGame=0, EndLevel=1, Level held. A start event SHALL move the FSM to PLAYING with Level=0.
REQ-022 GAME_WON: outputs EndGame=0, EndLevel=1, Win=1. A start event SHALL move the FSM to PLAYING with Level=0 and Win=0.
REQ-023 Start events in PLAYING and LEVEL_END SHALL have no effect.
REQ-024 The Level increment SHALL never wrap. It is bounded by NUM_LEVELS-1 per REQ-019.
REQ-025 Unused state encodings 5..7 SHALL recover to IDLE on the next clock, with Level=0 and Win=0.
REQ-026 Every state transition SHALL take effect one clock after the qualifying input is sampled. Outputs SHALL change in the same cycle as the state register.

Reset
REQ-027 RESET_InLow=0 SHALL asynchronously force:
- State=IDLE, Level=0, Win=0, EndGame=0, EndLevel=1;
- hold counter=0, start-edge register=1.
REQ-028 Reset asserted in any state, including mid-LEVEL_END, SHALL abort the operation immediately. No pending Level increment SHALL survive.
REQ-029 After reset deasserts, the block SHALL require a new start event to leave IDLE. A Start_InLow held low through reset SHALL NOT count as an edge.

Verification
REQ-030 Reset, then Start 1->0 -> State=1, EndGame=1, Level=0 one clock after the edge sample.
REQ-031 PLAYING, Progress ramps 0..24 (default parameters) -> at Progress=24, State=2 and EndLevel=0 for exactly 8 cycles, then State=1 and Level=1.
REQ-032 Run four levels with default parameters -> after the 4th LEVEL_END: State=4, Win=1, EndGame=0, Level=3. Then Start edge -> State=1, Level=0, Win=0.
REQ-033 PLAYING with Crash=0 and Progress=24 in the same cycle -> State=3, EndGame=0, Level unchanged. Crash asserted during LEVEL_END -> ignored, Level still increments.
REQ-034 Reset pulsed low at hold count 3 in LEVEL_END -> immediately State=0, Level=0, EndLevel=1. Start held low through reset release -> stays IDLE.
REQ-035 Start edge during PLAYING -> no change in State or Level. Force illegal state 6 -> IDLE next clock.
